mc_ctrl_unit: RTL and testbench

Parametrised multicycle control unit for the ARM-subset core. It combines the instruction decoder (main FSM, ALU decoder, op decoder) and the conditional-execution logic in one block. It adds a memory-ready wait handshake, an extended ALU command set selectable by parameter, and compare/test instructions without writeback. It sits between the instruction register and the datapath and drives every datapath select and write enable.

---
 rtl/mc_ctrl_unit.sv | 218 +++++++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_unit.sv
// rtl/mc_ctrl_unit.sv - multicycle control unit: main FSM, ALU decode, conditional execution
module mc_ctrl_unit #(
  parameter int         ALUCTRL_W  = 3,
  parameter bit         MEM_WAIT   = 1'b1,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [27:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Fault,
  output logic [3:0]           State
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_UNDEF  = 4'd10;

  // Instr carries bits [31:4] of the instruction word, so every field sits 4 lower.
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  assign cond  = Instr[27:24];
  assign op    = Instr[23:22];
  assign funct = Instr[21:16];
  assign rd    = Instr[11:8];

  logic [3:0] state, next_state;
  logic [3:0] flags;
  logic       condex_reg, cond_ex;
  logic       mem_rdy, in_exec;
  logic       nextpc, regw, memw, pcs, irw, fault_s;
  logic [2:0] alu3;
  logic [1:0] flagw;
  logic       nowrite;
  logic       unused_bits;

  assign mem_rdy     = MEM_WAIT ? MemReady : 1'b1;
  assign in_exec     = (state == S_EXECR) || (state == S_EXECI);
  assign unused_bits = ^{Instr[15:12], Instr[7:0], alu3};

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags      <= FLAG_RESET;
      condex_reg <= 1'b0;
    end else begin
      if (state == S_DECODE) condex_reg <= cond_ex;
      if (in_exec && condex_reg) begin
        if (flagw[1]) flags[3:2] <= ALUFlags[3:2];
        if (flagw[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          2'b00:   next_state = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   next_state = S_MEMADR;
          2'b10:   next_state = S_BRANCH;
          default: next_state = S_UNDEF;
        endcase
      end
      S_MEMADR: next_state = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXECR,
      S_EXECI:  next_state = nowrite ? S_FETCH : S_ALUWB;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    nextpc    = 1'b0;
    irw       = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    pcs       = 1'b0;
    fault_s   = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = mem_rdy;
        nextpc    = mem_rdy;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
        pcs       = (rd == 4'hF);
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECI:  ALUSrcB = 2'b01;
      S_ALUWB: begin
        regw = 1'b1;
        pcs  = (rd == 4'hF);
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcs       = 1'b1;
      end
      S_UNDEF:  fault_s = 1'b1;
      default: ;
    endcase
  end

  // Compare/test and undecodable commands share the NoWrite path back to FETCH.
  always_comb begin
    alu3    = 3'd0;
    flagw   = 2'b00;
    nowrite = 1'b0;
    if (in_exec) begin
      case (funct[4:1])
        4'b0100: begin alu3 = 3'd0; flagw = funct[0] ? 2'b11 : 2'b00; end
        4'b0010: begin alu3 = 3'd1; flagw = funct[0] ? 2'b11 : 2'b00; end
        4'b0000: begin alu3 = 3'd2; flagw = funct[0] ? 2'b10 : 2'b00; end
        4'b1100: begin alu3 = 3'd3; flagw = funct[0] ? 2'b10 : 2'b00; end
        4'b0001: begin
          if (ALUCTRL_W == 3) begin
            alu3  = 3'd4;
            flagw = funct[0] ? 2'b10 : 2'b00;
          end else begin
            nowrite = 1'b1;
          end
        end
        4'b1000: begin alu3 = 3'd2; flagw = 2'b10; nowrite = 1'b1; end
        4'b1010: begin alu3 = 3'd1; flagw = 2'b11; nowrite = 1'b1; end
        default: nowrite = 1'b1;
      endcase
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (op)
      2'b01: begin ImmSrc = 2'b01; RegSrc = {~funct[0], 1'b0}; end
      2'b10: begin ImmSrc = 2'b10; RegSrc = 2'b01; end
      default: ;
    endcase
  end

  always_comb begin
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign ALUControl = alu3[ALUCTRL_W-1:0];
  assign PCWrite    = reset & (nextpc | (pcs & condex_reg));
  assign RegWrite   = reset & regw & condex_reg;
  assign MemWrite   = reset & memw & condex_reg;
  assign IRWrite    = reset & irw;
  assign Fault      = reset & fault_s;
  assign State      = state;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb/tb_mc_ctrl_unit.sv - scoreboard bench for mc_ctrl_unit
module tb_mc_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic [27:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;

  logic       PCWrite1, MemWrite1, RegWrite1, IRWrite1, AdrSrc1, Fault1;
  logic [1:0] RegSrc1, ALUSrcA1, ALUSrcB1, ResultSrc1, ImmSrc1;
  logic [2:0] ALUControl1;
  logic [3:0] State1;

  logic       PCWrite2, MemWrite2, RegWrite2, IRWrite2, AdrSrc2, Fault2;
  logic [1:0] RegSrc2, ALUSrcA2, ALUSrcB2, ResultSrc2, ImmSrc2;
  logic [1:0] ALUControl2;
  logic [3:0] State2;

  mc_ctrl_unit #(.ALUCTRL_W(3), .MEM_WAIT(1'b1), .FLAG_RESET(4'b0000)) u1 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite1), .MemWrite(MemWrite1), .RegWrite(RegWrite1), .IRWrite(IRWrite1),
    .AdrSrc(AdrSrc1), .RegSrc(RegSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
    .ResultSrc(ResultSrc1), .ImmSrc(ImmSrc1), .ALUControl(ALUControl1), .Fault(Fault1),
    .State(State1)
  );

  mc_ctrl_unit #(.ALUCTRL_W(2), .MEM_WAIT(1'b1), .FLAG_RESET(4'b0000)) u2 (
    .clk(clk), .reset(reset2), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite2), .MemWrite(MemWrite2), .RegWrite(RegWrite2), .IRWrite(IRWrite2),
    .AdrSrc(AdrSrc2), .RegSrc(RegSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
    .ResultSrc(ResultSrc2), .ImmSrc(ImmSrc2), .ALUControl(ALUControl2), .Fault(Fault2),
    .State(State2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       sel;
    logic [3:0] st;
    logic [4:0] we;   // {PCWrite, MemWrite, RegWrite, IRWrite, Fault}
    int         rs;   // -1: ResultSrc not checked
    int         al;   // -1: ALUControl not checked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic set_i(input logic [31:0] f);
    Instr = f[31:4];
  endtask

  task automatic step(input string nm, input logic sel, input logic [3:0] st,
                      input logic [4:0] we, input logic mr, input int rs, input int al);
    exp_t e;
    MemReady = mr;
    e.nm = nm; e.sel = sel; e.st = st; e.we = we; e.rs = rs; e.al = al;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t       e;
      logic [3:0] a_st;
      logic [4:0] a_we;
      logic [1:0] a_rs;
      logic [2:0] a_al;
      logic       bad;
      e = exp_q.pop_front();
      if (e.sel) begin
        a_st = State2;
        a_we = {PCWrite2, MemWrite2, RegWrite2, IRWrite2, Fault2};
        a_rs = ResultSrc2;
        a_al = {1'b0, ALUControl2};
      end else begin
        a_st = State1;
        a_we = {PCWrite1, MemWrite1, RegWrite1, IRWrite1, Fault1};
        a_rs = ResultSrc1;
        a_al = ALUControl1;
      end
      checks++;
      bad = (a_st !== e.st) || (a_we !== e.we);
      if (e.rs >= 0 && a_rs !== e.rs[1:0]) bad = 1'b1;
      if (e.al >= 0 && a_al !== e.al[2:0]) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL %s: got st=%0d we=%b rs=%b al=%0d, want st=%0d we=%b rs=%0d al=%0d",
                 e.nm, a_st, a_we, a_rs, a_al, e.st, e.we, e.rs, e.al);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; reset2 = 1'b0; MemReady = 1'b1; ALUFlags = 4'b0000; set_i(32'h0);
    @(posedge clk); #1;
    step("rst0", 0, 0, 5'b00000, 1, 2, 0);
    step("rst1", 0, 0, 5'b00000, 1, 2, 0);
    reset = 1'b1;

    // ADD R1,R2,R3 with one fetch wait
    set_i(32'hE0821003);
    step("add_fwait", 0, 0, 5'b00000, 0, 2, 0);
    step("add_f",     0, 0, 5'b10010, 1, 2, 0);
    step("add_d",     0, 1, 5'b00000, 1, 2, 0);
    step("add_x",     0, 6, 5'b00000, 1, -1, 0);
    step("add_wb",    0, 8, 5'b00100, 1, 0, 0);

    // ADD R1,R2,#1
    set_i(32'hE2821001);
    step("addi_f",  0, 0, 5'b10010, 1, 2, 0);
    step("addi_d",  0, 1, 5'b00000, 1, 2, 0);
    step("addi_x",  0, 7, 5'b00000, 1, -1, 0);
    step("addi_wb", 0, 8, 5'b00100, 1, 0, 0);

    // ADD PC,R2,R3 writes the PC in ALUWB
    set_i(32'hE082F003);
    step("addpc_f",  0, 0, 5'b10010, 1, 2, 0);
    step("addpc_d",  0, 1, 5'b00000, 1, 2, 0);
    step("addpc_x",  0, 6, 5'b00000, 1, -1, 0);
    step("addpc_wb", 0, 8, 5'b10100, 1, 0, 0);

    // CMP R0,R0 with Z=1 result, then BEQ taken
    ALUFlags = 4'b0100;
    set_i(32'hE1500000);
    step("cmp_f", 0, 0, 5'b10010, 1, 2, 0);
    step("cmp_d", 0, 1, 5'b00000, 1, 2, 0);
    step("cmp_x", 0, 6, 5'b00000, 1, -1, 1);
    set_i(32'h0A000002);
    step("beqt_f", 0, 0, 5'b10010, 1, 2, 0);
    step("beqt_d", 0, 1, 5'b00000, 1, 2, 0);
    step("beqt_b", 0, 9, 5'b10000, 1, 2, 0);

    // SUBSEQ clears Z during its own EXEC yet still writes back
    ALUFlags = 4'b0000;
    set_i(32'h00500000);
    step("subs_f",  0, 0, 5'b10010, 1, 2, 0);
    step("subs_d",  0, 1, 5'b00000, 1, 2, 0);
    step("subs_x",  0, 6, 5'b00000, 1, -1, 1);
    step("subs_wb", 0, 8, 5'b00100, 1, 0, 0);
    set_i(32'h0A000002);
    step("beqn_f", 0, 0, 5'b10010, 1, 2, 0);
    step("beqn_d", 0, 1, 5'b00000, 1, 2, 0);
    step("beqn_b", 0, 9, 5'b00000, 1, 2, 0);

    // TST R0,R0: no writeback
    set_i(32'hE1100000);
    step("tst_f", 0, 0, 5'b10010, 1, 2, 0);
    step("tst_d", 0, 1, 5'b00000, 1, 2, 0);
    step("tst_x", 0, 6, 5'b00000, 1, -1, 2);

    // CMP sets Z, then STRNE is suppressed
    ALUFlags = 4'b0100;
    set_i(32'hE1500000);
    step("cmp2_f", 0, 0, 5'b10010, 1, 2, 0);
    step("cmp2_d", 0, 1, 5'b00000, 1, 2, 0);
    step("cmp2_x", 0, 6, 5'b00000, 1, -1, 1);
    set_i(32'h15801000);
    step("strne_f",  0, 0, 5'b10010, 1, 2, 0);
    step("strne_d",  0, 1, 5'b00000, 1, 2, 0);
    step("strne_a",  0, 2, 5'b00000, 1, -1, 0);
    step("strne_w0", 0, 5, 5'b00000, 0, 0, 0);
    step("strne_w1", 0, 5, 5'b00000, 1, 0, 0);

    // STR AL with one memory wait
    set_i(32'hE5801000);
    step("str_f",  0, 0, 5'b10010, 1, 2, 0);
    step("str_d",  0, 1, 5'b00000, 1, 2, 0);
    step("str_a",  0, 2, 5'b00000, 1, -1, 0);
    step("str_w0", 0, 5, 5'b01000, 0, 0, 0);
    step("str_w1", 0, 5, 5'b01000, 1, 0, 0);

    // LDR with three wait cycles in MEMRD
    set_i(32'hE5901000);
    step("ldr_f",  0, 0, 5'b10010, 1, 2, 0);
    step("ldr_d",  0, 1, 5'b00000, 1, 2, 0);
    step("ldr_a",  0, 2, 5'b00000, 1, -1, 0);
    for (int i = 0; i < 3; i++) step("ldr_rwait", 0, 3, 5'b00000, 0, 0, 0);
    step("ldr_r",  0, 3, 5'b00000, 1, 0, 0);
    step("ldr_wb", 0, 4, 5'b00100, 1, 1, 0);

    // Op=11 faults
    set_i(32'hEC000000);
    step("und_f", 0, 0, 5'b10010, 1, 2, 0);
    step("und_d", 0, 1, 5'b00000, 1, 2, 0);
    step("und_u", 0, 10, 5'b00001, 1, -1, 0);

    // EOR with the 3-bit ALU command set
    set_i(32'hE0221003);
    step("eor3_f",  0, 0, 5'b10010, 1, 2, 0);
    step("eor3_d",  0, 1, 5'b00000, 1, 2, 0);
    step("eor3_x",  0, 6, 5'b00000, 1, -1, 4);
    step("eor3_wb", 0, 8, 5'b00100, 1, 0, 0);

    // Reset during MEMWR aborts the store
    set_i(32'hE5801000);
    step("strr_f", 0, 0, 5'b10010, 1, 2, 0);
    step("strr_d", 0, 1, 5'b00000, 1, 2, 0);
    step("strr_a", 0, 2, 5'b00000, 1, -1, 0);
    reset = 1'b0;
    step("strr_w", 0, 5, 5'b00000, 0, 0, 0);
    step("strr_0", 0, 0, 5'b00000, 1, 2, 0);

    // EOR on the 2-bit ALU variant is undefined: NoWrite path
    set_i(32'hE0221003);
    reset2 = 1'b1;
    step("eor2_f",    1, 0, 5'b10010, 1, 2, 0);
    step("eor2_d",    1, 1, 5'b00000, 1, 2, 0);
    step("eor2_x",    1, 6, 5'b00000, 1, -1, 0);
    step("eor2_back", 1, 0, 5'b10010, 1, 2, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
